inst_fetch: RTL and testbench

Instruction fetch stage for the 9-bit processor. It owns the program counter, drives the 8-bit address into the combinational instruction ROM and captures the returned 9-bit instruction word into a fetch register. It hands that register to decode over a valid/ready handshake. It also handles branch redirects from execute, halt-instruction detection and a retired-fetch counter.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/sat_counter.sv | 33 +++
 rtl/inst_fetch.sv | 110 +++++++++++
 tb/tb_inst_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and widths; decode imports HALT_INST_DEFAULT so
// both stages agree on the halt encoding.
package fetch_pkg;

   localparam int PC_W   = 8;
   localparam int INST_W = 9;
   localparam int CNT_W  = 16;

   localparam logic [INST_W-1:0] HALT_INST_DEFAULT = 9'h1FF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC drives the combinational ROM, the returned word is captured
// into IR and offered to decode; branches redirect, HALT_INST stops fetching.
module inst_fetch
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0]   RESET_PC  = 8'h00,
   parameter logic [INST_W-1:0] HALT_INST = HALT_INST_DEFAULT
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Start,
   output logic [PC_W-1:0]   Address,
   input  logic [INST_W-1:0] Instruction,
   input  logic              BranchTaken,
   input  logic [PC_W-1:0]   BranchTarget,
   output logic [INST_W-1:0] IR,
   output logic              IRValid,
   input  logic              IRReady,
   output logic              Halted,
   output logic [CNT_W-1:0]  InstCount,
   output fetch_state_t      DbgState
);

   // IR/IRValid is a valid/ready source: a word transfers on an edge where
   // IRValid && IRReady; while IRValid && !IRReady, IR and IRValid hold unless
   // a branch or Start squashes the word.

   fetch_state_t      state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [INST_W-1:0] ir_q, ir_d;
   logic              ir_valid_q, ir_valid_d;
   logic              halted_q, halted_d;
   logic              load, accept, redirect;

   assign redirect = BranchTaken && (state_q != ST_IDLE);
   assign load     = (state_q == ST_RUN) && !BranchTaken && (!ir_valid_q || IRReady);
   assign accept   = ir_valid_q && IRReady && !BranchTaken;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      halted_d   = halted_q;
      if (Start) begin
         state_d    = ST_RUN;
         pc_d       = RESET_PC;
         ir_valid_d = 1'b0;
         halted_d   = 1'b0;
      end else if (redirect) begin
         state_d    = ST_RUN;
         pc_d       = BranchTarget;
         ir_valid_d = 1'b0;
         halted_d   = 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (load) begin
                  ir_d       = Instruction;
                  ir_valid_d = 1'b1;
                  // The PC stays on the halt word so Address points at it.
                  if (Instruction == HALT_INST) begin
                     state_d  = ST_HALTED;
                     halted_d = 1'b1;
                  end else begin
                     pc_d = pc_q + 8'd1;
                  end
               end
            end
            ST_HALTED: begin
               if (accept) begin
                  ir_valid_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         halted_q   <= halted_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_inst_count (
      .clk     (Clk),
      .rst_n   (Reset_n),
      .clr_i   (Start),
      .en_i    (accept),
      .count_o (InstCount)
   );

   assign Address  = pc_q;
   assign IR       = ir_q;
   assign IRValid  = ir_valid_q;
   assign Halted   = halted_q;
   assign DbgState = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: ROM returns Address+0x010 (0x1FF at 0x05 when armed);
// delivered words are checked against an expected queue.
module tb_inst_fetch;
   import fetch_pkg::*;

   logic         Clk;
   logic         Reset_n;
   logic         Start;
   logic [7:0]   Address;
   logic [8:0]   Instruction;
   logic         BranchTaken;
   logic [7:0]   BranchTarget;
   logic [8:0]   IR;
   logic         IRValid;
   logic         IRReady;
   logic         Halted;
   logic [15:0]  InstCount;
   fetch_state_t DbgState;

   logic         halt_en;
   logic         sb_en;
   logic [8:0]   exp_q[$];
   logic [8:0]   exp_w;
   int           n_cmp;
   int           n_bad;

   inst_fetch dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .Start        (Start),
      .Address      (Address),
      .Instruction  (Instruction),
      .BranchTaken  (BranchTaken),
      .BranchTarget (BranchTarget),
      .IR           (IR),
      .IRValid      (IRValid),
      .IRReady      (IRReady),
      .Halted       (Halted),
      .InstCount    (InstCount),
      .DbgState     (DbgState)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   assign Instruction = (halt_en && (Address == 8'h05)) ? 9'h1FF : ({1'b0, Address} + 9'h010);

   // scoreboard: every word decode accepts must match the queue head
   always @(negedge Clk) begin
      if (sb_en && Reset_n && IRValid && IRReady && !BranchTaken) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: got IR %h, want no delivery", IR);
         end else begin
            exp_w = exp_q.pop_front();
            if (IR !== exp_w) begin
               n_bad++;
               $display("FAIL sb_ir: got %h want %h", IR, exp_w);
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      n_cmp++; if (IRValid !== 1'b0)   begin n_bad++; $display("FAIL rst_valid: got %b want 0", IRValid); end
      n_cmp++; if (Address !== 8'h00)  begin n_bad++; $display("FAIL rst_addr: got %h want 00", Address); end
      n_cmp++; if (IR !== 9'h000)      begin n_bad++; $display("FAIL rst_ir: got %h want 000", IR); end
      n_cmp++; if (Halted !== 1'b0)    begin n_bad++; $display("FAIL rst_halted: got %b want 0", Halted); end
      n_cmp++; if (InstCount !== 16'h0) begin n_bad++; $display("FAIL rst_count: got %h want 0000", InstCount); end
      n_cmp++; if (DbgState !== ST_IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want IDLE", DbgState); end
      @(negedge Clk);
      Reset_n = 1'b1;
      // branches are ignored while idle
      BranchTaken  = 1'b1;
      BranchTarget = 8'h33;
      tick();
      tick();
      n_cmp++; if (DbgState !== ST_IDLE) begin n_bad++; $display("FAIL idle_branch_state: got %0d want IDLE", DbgState); end
      n_cmp++; if (Address !== 8'h00)  begin n_bad++; $display("FAIL idle_branch_addr: got %h want 00", Address); end
      n_cmp++; if (IRValid !== 1'b0)   begin n_bad++; $display("FAIL idle_branch_valid: got %b want 0", IRValid); end
      BranchTaken = 1'b0;
   endtask

   task automatic test_start();
      IRReady = 1'b1;
      exp_q.push_back(9'h010);
      exp_q.push_back(9'h011);
      exp_q.push_back(9'h012);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      n_cmp++; if (DbgState !== ST_RUN) begin n_bad++; $display("FAIL start_state: got %0d want RUN", DbgState); end
      n_cmp++; if (Address !== 8'h00) begin n_bad++; $display("FAIL start_addr: got %h want 00", Address); end
      n_cmp++; if (IRValid !== 1'b0)  begin n_bad++; $display("FAIL start_valid: got %b want 0", IRValid); end
      tick();
      n_cmp++; if (IRValid !== 1'b1 || IR !== 9'h010) begin n_bad++; $display("FAIL start_first: got %b/%h want 1/010", IRValid, IR); end
      tick();
      tick();
      n_cmp++; if (IR !== 9'h012)       begin n_bad++; $display("FAIL start_third: got %h want 012", IR); end
      n_cmp++; if (InstCount !== 16'd2) begin n_bad++; $display("FAIL start_count: got %0d want 2", InstCount); end
   endtask

   task automatic test_stall();
      IRReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (IR !== 9'h012 || IRValid !== 1'b1) begin n_bad++; $display("FAIL stall_ir[%0d]: got %b/%h want 1/012", i, IRValid, IR); end
         n_cmp++; if (Address !== 8'h03) begin n_bad++; $display("FAIL stall_addr[%0d]: got %h want 03", i, Address); end
         n_cmp++; if (InstCount !== 16'd2) begin n_bad++; $display("FAIL stall_count[%0d]: got %0d want 2", i, InstCount); end
      end
      IRReady = 1'b1;
      tick();
      n_cmp++; if (IR !== 9'h013 || IRValid !== 1'b1) begin n_bad++; $display("FAIL stall_release: got %b/%h want 1/013", IRValid, IR); end
      n_cmp++; if (InstCount !== 16'd3) begin n_bad++; $display("FAIL stall_count_after: got %0d want 3", InstCount); end
   endtask

   task automatic test_branch();
      BranchTaken  = 1'b1;
      BranchTarget = 8'h40;
      tick();
      BranchTaken = 1'b0;
      n_cmp++; if (IRValid !== 1'b0)   begin n_bad++; $display("FAIL br_squash: got %b want 0", IRValid); end
      n_cmp++; if (Address !== 8'h40)  begin n_bad++; $display("FAIL br_addr: got %h want 40", Address); end
      n_cmp++; if (InstCount !== 16'd3) begin n_bad++; $display("FAIL br_count: got %0d want 3", InstCount); end
      exp_q.push_back(9'h050);
      tick();
      n_cmp++; if (IRValid !== 1'b1 || IR !== 9'h050) begin n_bad++; $display("FAIL br_target: got %b/%h want 1/050", IRValid, IR); end
   endtask

   task automatic test_halt();
      halt_en = 1'b1;
      for (int a = 0; a < 5; a++) exp_q.push_back(9'h010 + 9'(a));
      exp_q.push_back(9'h1FF);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      n_cmp++; if (InstCount !== 16'd0) begin n_bad++; $display("FAIL halt_restart_count: got %0d want 0", InstCount); end
      for (int i = 0; i < 6; i++) tick();
      n_cmp++; if (IR !== 9'h1FF || IRValid !== 1'b1) begin n_bad++; $display("FAIL halt_ir: got %b/%h want 1/1FF", IRValid, IR); end
      n_cmp++; if (Halted !== 1'b1)    begin n_bad++; $display("FAIL halt_flag: got %b want 1", Halted); end
      n_cmp++; if (Address !== 8'h05)  begin n_bad++; $display("FAIL halt_addr: got %h want 05", Address); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (IRValid !== 1'b0 || Address !== 8'h05 || Halted !== 1'b1) begin n_bad++; $display("FAIL halt_hold[%0d]: got v%b a%h h%b want v0 a05 h1", i, IRValid, Address, Halted); end
      end
      n_cmp++; if (InstCount !== 16'd6) begin n_bad++; $display("FAIL halt_count: got %0d want 6", InstCount); end
      n_cmp++; if (DbgState !== ST_HALTED) begin n_bad++; $display("FAIL halt_state: got %0d want HALTED", DbgState); end
      BranchTaken  = 1'b1;
      BranchTarget = 8'h20;
      tick();
      BranchTaken = 1'b0;
      n_cmp++; if (Halted !== 1'b0 || Address !== 8'h20) begin n_bad++; $display("FAIL halt_resume: got h%b a%h want h0 a20", Halted, Address); end
      tick();
      n_cmp++; if (IR !== 9'h030 || IRValid !== 1'b1) begin n_bad++; $display("FAIL halt_resume_ir: got %b/%h want 1/030", IRValid, IR); end
      halt_en = 1'b0;
   endtask

   task automatic test_wrap();
      // branch in the same cycle squashes 0x030 before it is accepted
      BranchTaken  = 1'b1;
      BranchTarget = 8'hFE;
      tick();
      BranchTaken = 1'b0;
      n_cmp++; if (Address !== 8'hFE) begin n_bad++; $display("FAIL wrap_fe: got %h want FE", Address); end
      exp_q.push_back(9'h10E);
      exp_q.push_back(9'h10F);
      tick();
      n_cmp++; if (Address !== 8'hFF) begin n_bad++; $display("FAIL wrap_ff: got %h want FF", Address); end
      tick();
      n_cmp++; if (Address !== 8'h00 || IR !== 9'h10F) begin n_bad++; $display("FAIL wrap_00: got a%h ir%h want a00 ir10F", Address, IR); end
      tick();
      IRReady = 1'b0;
      n_cmp++; if (IR !== 9'h010) begin n_bad++; $display("FAIL wrap_ir: got %h want 010", IR); end
      n_cmp++; if (InstCount !== 16'd8) begin n_bad++; $display("FAIL wrap_count: got %0d want 8", InstCount); end
   endtask

   task automatic test_async_reset();
      #2;
      Reset_n = 1'b0;
      #1;
      n_cmp++; if (IRValid !== 1'b0)    begin n_bad++; $display("FAIL arst_valid: got %b want 0", IRValid); end
      n_cmp++; if (Address !== 8'h00)   begin n_bad++; $display("FAIL arst_addr: got %h want 00", Address); end
      n_cmp++; if (InstCount !== 16'h0) begin n_bad++; $display("FAIL arst_count: got %0d want 0", InstCount); end
      n_cmp++; if (DbgState !== ST_IDLE) begin n_bad++; $display("FAIL arst_state: got %0d want IDLE", DbgState); end
      @(negedge Clk);
      Reset_n = 1'b1;
      IRReady = 1'b1;
      tick();
      tick();
      n_cmp++; if (DbgState !== ST_IDLE || IRValid !== 1'b0) begin n_bad++; $display("FAIL arst_idle: got s%0d v%b want IDLE v0", DbgState, IRValid); end
   endtask

   task automatic test_saturate();
      sb_en   = 1'b0;
      IRReady = 1'b1;
      Start   = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 65535; i++) tick();
      n_cmp++; if (InstCount !== 16'hFFFE) begin n_bad++; $display("FAIL sat_pre: got %h want FFFE", InstCount); end
      tick();
      n_cmp++; if (InstCount !== 16'hFFFF) begin n_bad++; $display("FAIL sat_max: got %h want FFFF", InstCount); end
      for (int i = 0; i < 3; i++) tick();
      n_cmp++; if (InstCount !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %h want FFFF", InstCount); end
   endtask

   initial begin
      n_cmp        = 0;
      n_bad        = 0;
      Reset_n      = 1'b0;
      Start        = 1'b0;
      BranchTaken  = 1'b0;
      BranchTarget = 8'h00;
      IRReady      = 1'b0;
      halt_en      = 1'b0;
      sb_en        = 1'b1;
      test_reset();
      test_start();
      test_stall();
      test_branch();
      test_halt();
      test_wrap();
      test_async_reset();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain: got %0d words left want 0", exp_q.size());
      end
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
